// File: rtl/lumi_cfg_seq.sv
// rtl/lumi_cfg_seq.sv - host-side LUMI remote configuration sequencer
// Writes remote credit/RX/TX registers over UMI, then reads STATUS to confirm link.
module lumi_cfg_seq #(
  parameter int            CW             = 32,
  parameter int            AW             = 64,
  parameter int            RW             = 32,
  parameter logic [AW-1:0] REGBASE        = '0,
  parameter logic [AW-1:0] SRCADDR        = '0,
  parameter logic [7:0]    OFF_STATUS     = 8'h04,
  parameter logic [7:0]    OFF_TXMODE     = 8'h10,
  parameter logic [7:0]    OFF_RXMODE     = 8'h14,
  parameter logic [7:0]    OFF_CRDTINIT   = 8'h20,
  parameter logic [7:0]    OFF_CRDTINTRVL = 8'h24,
  parameter int            TIMEOUT        = 1023
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    cfg_txiowidth,
  input  logic [7:0]    cfg_rxiowidth,
  input  logic          cfg_txcrdt_en,
  input  logic [15:0]   cfg_crdt_req,
  input  logic [15:0]   cfg_crdt_resp,
  input  logic [15:0]   cfg_crdt_intrvl,
  output logic          uhost_req_valid,
  output logic [CW-1:0] uhost_req_cmd,
  output logic [AW-1:0] uhost_req_dstaddr,
  output logic [AW-1:0] uhost_req_srcaddr,
  output logic [RW-1:0] uhost_req_data,
  input  logic          uhost_req_ready,
  input  logic          uhost_resp_valid,
  input  logic [CW-1:0] uhost_resp_cmd,
  input  logic [RW-1:0] uhost_resp_data,
  output logic          uhost_resp_ready,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_error,
  output logic [2:0]    cfg_step
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERROR} state_t;

  localparam logic [4:0] OP_RD     = 5'h01;
  localparam logic [4:0] OP_WR     = 5'h03;
  localparam logic [4:0] OP_RDRESP = 5'h02;
  localparam logic [4:0] OP_WRACK  = 5'h04;
  localparam logic [9:0] TMO_MAX   = 10'(TIMEOUT);
  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT - 1);

  state_t        state, state_next;
  logic [2:0]    step, step_next;
  logic [9:0]    tmo_cnt;
  logic          resp_ok;
  logic [7:0]    ld_off;
  logic [4:0]    ld_op;
  logic [RW-1:0] ld_data;
  logic          unused_resp_bits;

  assign unused_resp_bits = ^{uhost_resp_cmd[CW-1:5], uhost_resp_data};

  // The status read must also see the remote linkactive bit.
  always_comb begin
    resp_ok = 1'b0;
    if (step == 3'd4)
      resp_ok = (uhost_resp_cmd[4:0] == OP_RDRESP) && uhost_resp_data[4];
    else
      resp_ok = (uhost_resp_cmd[4:0] == OP_WRACK);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Abort on start low takes priority over any response or timeout.
  always_comb begin
    state_next = state;
    step_next  = step;
    case (state)
      S_IDLE:  if (start) begin
                 state_next = S_ISSUE;
                 step_next  = 3'd0;
               end
      S_ISSUE: if (!start)              state_next = S_IDLE;
               else if (uhost_req_ready) state_next = S_WAIT;
      S_WAIT:  if (!start) state_next = S_IDLE;
               else if (uhost_resp_valid) begin
                 if (!resp_ok)            state_next = S_ERROR;
                 else if (step == 3'd4)   state_next = S_DONE;
                 else begin
                   state_next = S_ISSUE;
                   step_next  = step + 3'd1;
                 end
               end
               else if (tmo_cnt == TMO_LAST) state_next = S_ERROR;
      S_DONE,
      S_ERROR: if (!start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (state_next == S_IDLE) step_next = 3'd0;
  end

  always_comb begin
    ld_off  = OFF_STATUS;
    ld_op   = OP_RD;
    ld_data = '0;
    case (step_next)
      3'd0: begin ld_off = OFF_CRDTINIT;   ld_op = OP_WR; ld_data = RW'({cfg_crdt_resp, cfg_crdt_req}); end
      3'd1: begin ld_off = OFF_CRDTINTRVL; ld_op = OP_WR; ld_data = RW'({16'h0, cfg_crdt_intrvl}); end
      3'd2: begin ld_off = OFF_RXMODE;     ld_op = OP_WR; ld_data = RW'({8'h0, cfg_rxiowidth, 15'h0, 1'b1}); end
      3'd3: begin ld_off = OFF_TXMODE;     ld_op = OP_WR;
                  ld_data = RW'({8'h0, cfg_txiowidth, 11'h0, cfg_txcrdt_en, 3'h0, 1'b1}); end
      default: ;
    endcase
  end

  // Request fields are captured on entry to ISSUE and held until the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step              <= 3'd0;
      tmo_cnt           <= 10'd0;
      uhost_req_valid   <= 1'b0;
      uhost_req_cmd     <= '0;
      uhost_req_dstaddr <= '0;
      uhost_req_srcaddr <= '0;
      uhost_req_data    <= '0;
    end else begin
      step <= step_next;
      if (state == S_ISSUE)
        tmo_cnt <= 10'd0;
      else if (state == S_WAIT && tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + 10'd1;
      uhost_req_valid <= (state_next == S_ISSUE);
      if (state_next == S_ISSUE && state != S_ISSUE) begin
        uhost_req_cmd     <= CW'({16'h0, 8'h00, 3'd2, ld_op});
        uhost_req_dstaddr <= REGBASE + AW'(ld_off);
        uhost_req_srcaddr <= SRCADDR;
        uhost_req_data    <= ld_data;
      end else if (state_next != S_ISSUE) begin
        uhost_req_cmd     <= '0;
        uhost_req_dstaddr <= '0;
        uhost_req_srcaddr <= '0;
        uhost_req_data    <= '0;
      end
    end
  end

  always_comb begin
    cfg_busy         = (state == S_ISSUE) || (state == S_WAIT);
    cfg_done         = (state == S_DONE);
    cfg_error        = (state == S_ERROR);
    uhost_resp_ready = 1'b1;
    cfg_step         = step;
  end

endmodule

// File: tb/tb_lumi_cfg_seq.sv
// tb/tb_lumi_cfg_seq.sv - randomized self-checking bench for lumi_cfg_seq
// Transaction-level reference model plus literal checks of the documented sequence.
module tb_lumi_cfg_seq;

  localparam int          TMO  = 1023;
  localparam logic [63:0] SRCA = 64'h0000_00AB_CD00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_txiowidth = 8'h0, cfg_rxiowidth = 8'h0;
  logic        cfg_txcrdt_en = 1'b0;
  logic [15:0] cfg_crdt_req = 16'h0, cfg_crdt_resp = 16'h0, cfg_crdt_intrvl = 16'h0;
  logic        uhost_req_valid;
  logic [31:0] uhost_req_cmd;
  logic [63:0] uhost_req_dstaddr, uhost_req_srcaddr;
  logic [31:0] uhost_req_data;
  logic        uhost_req_ready = 1'b1;
  logic        uhost_resp_valid = 1'b0;
  logic [31:0] uhost_resp_cmd = 32'h0;
  logic [31:0] uhost_resp_data = 32'h0;
  logic        uhost_resp_ready;
  logic        cfg_busy, cfg_done, cfg_error;
  logic [2:0]  cfg_step;

  lumi_cfg_seq #(.SRCADDR(SRCA)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_txiowidth(cfg_txiowidth), .cfg_rxiowidth(cfg_rxiowidth),
    .cfg_txcrdt_en(cfg_txcrdt_en), .cfg_crdt_req(cfg_crdt_req),
    .cfg_crdt_resp(cfg_crdt_resp), .cfg_crdt_intrvl(cfg_crdt_intrvl),
    .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
    .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
    .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
    .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_error(cfg_error), .cfg_step(cfg_step)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus knobs
  int          ready_pct = 100;
  int          stall_left = 0;
  logic [7:0]  stall_off = 8'h00;
  bit          cfg_rand = 1'b0;
  int          lat_min = 0, lat_max = 0;
  logic [31:0] status_val = 32'h10;
  int          bad_pct = 0;
  bit          drop_en = 1'b0;
  logic [7:0]  drop_off = 8'h00;
  bit          badop_en = 1'b0;
  logic [7:0]  badop_off = 8'h00;

  // Ready and config driver
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && uhost_req_valid && uhost_req_dstaddr[7:0] == stall_off) begin
      uhost_req_ready = 1'b0;
      stall_left--;
    end else begin
      uhost_req_ready = ($urandom_range(0, 99) < ready_pct);
    end
    if (cfg_rand) begin
      cfg_txiowidth   = 8'($urandom);
      cfg_rxiowidth   = 8'($urandom);
      cfg_txcrdt_en   = 1'($urandom);
      cfg_crdt_req    = 16'($urandom);
      cfg_crdt_resp   = 16'($urandom);
      cfg_crdt_intrvl = 16'($urandom);
    end
  end

  // Remote register responder
  initial begin
    logic [7:0]  off;
    logic        rd;
    logic [4:0]  op;
    logic [31:0] rc;
    int          lat;
    logic [4:0]  bad_ops [6];
    bad_ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h1f};
    forever begin
      @(negedge clk);
      if (!reset && uhost_req_valid && uhost_req_ready) begin
        off = uhost_req_dstaddr[7:0];
        rd  = (uhost_req_cmd[4:0] == 5'h01);
        @(posedge clk);
        if (!(drop_en && off == drop_off)) begin
          lat = $urandom_range(lat_min, lat_max);
          repeat (lat) @(posedge clk);
          #1;
          op = rd ? 5'h02 : 5'h04;
          if (badop_en && off == badop_off) op = 5'h02;
          if (bad_pct > 0 && $urandom_range(0, 99) < bad_pct) op = bad_ops[$urandom_range(0, 5)];
          rc = $urandom;
          rc[4:0] = op;
          uhost_resp_cmd   = rc;
          uhost_resp_data  = rd ? status_val : $urandom;
          uhost_resp_valid = 1'b1;
          @(posedge clk); #1;
          uhost_resp_valid = 1'b0;
        end
      end
    end
  end

  // Request log and stall/handshake monitor
  logic [63:0] log_dst [$];
  logic [31:0] log_data [$];
  logic [31:0] log_cmd [$];
  int hs_edge_24 = 0;
  int stall_cnt = 0;
  initial forever begin
    @(negedge clk);
    if (!reset && uhost_req_valid && uhost_req_ready) begin
      log_dst.push_back(uhost_req_dstaddr);
      log_data.push_back(uhost_req_data);
      log_cmd.push_back(uhost_req_cmd);
      if (uhost_req_dstaddr[7:0] == 8'h24) hs_edge_24 = cyc + 1;
    end
    if (!reset && uhost_req_valid && !uhost_req_ready && uhost_req_dstaddr[7:0] == 8'h14)
      stall_cnt++;
  end

  // Behavioural reference model: position in the five-transaction script
  localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_DONE = 3, PH_ERR = 4;
  logic [7:0]  offs [5] = '{8'h20, 8'h24, 8'h14, 8'h10, 8'h04};
  int          m_phase = PH_IDLE;
  int          m_step = 0;
  int          m_wait = 0;
  logic [31:0] m_cmd = 32'h0, m_data = 32'h0;
  logic [63:0] m_dst = 64'h0;
  bit          good;

  function automatic logic [31:0] exp_data(input int s);
    case (s)
      0: return (32'(cfg_crdt_resp) << 16) | 32'(cfg_crdt_req);
      1: return 32'(cfg_crdt_intrvl);
      2: return (32'(cfg_rxiowidth) << 16) | 32'd1;
      3: return (32'(cfg_txiowidth) << 16) | (32'(cfg_txcrdt_en) << 4) | 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  task automatic latch_req();
    m_dst  = 64'(offs[m_step]);
    m_cmd  = 32'h40 | ((m_step == 4) ? 32'd1 : 32'd3);
    m_data = exp_data(m_step);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = PH_IDLE; m_step = 0; m_wait = 0;
    end else if (!start) begin
      m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: begin m_step = 0; m_phase = PH_REQ; latch_req(); end
        PH_REQ:  if (uhost_req_ready) begin m_phase = PH_WAIT; m_wait = 0; end
        PH_WAIT: if (uhost_resp_valid) begin
                   if (m_step == 4) good = (uhost_resp_cmd[4:0] == 5'h02) && uhost_resp_data[4];
                   else             good = (uhost_resp_cmd[4:0] == 5'h04);
                   if (!good)             m_phase = PH_ERR;
                   else if (m_step == 4)  m_phase = PH_DONE;
                   else begin m_step++; m_phase = PH_REQ; latch_req(); end
                 end else begin
                   m_wait++;
                   if (m_wait >= TMO) m_phase = PH_ERR;
                 end
        default: ;
      endcase
    end
  end

  // Per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("rst_valid", uhost_req_valid, 0);
      chk("rst_cmd", uhost_req_cmd, 0);
      chk("rst_dst", uhost_req_dstaddr, 0);
      chk("rst_src", uhost_req_srcaddr, 0);
      chk("rst_data", uhost_req_data, 0);
      chk("rst_resp_ready", uhost_resp_ready, 1);
      chk("rst_flags", {cfg_busy, cfg_done, cfg_error}, 0);
      chk("rst_step", cfg_step, 0);
    end else begin
      chk("req_valid", uhost_req_valid, m_phase == PH_REQ);
      chk("resp_ready", uhost_resp_ready, 1);
      chk("busy", cfg_busy, m_phase == PH_REQ || m_phase == PH_WAIT);
      chk("done", cfg_done, m_phase == PH_DONE);
      chk("error", cfg_error, m_phase == PH_ERR);
      if (m_phase != PH_IDLE) chk("step", cfg_step, 64'(m_step));
      if (m_phase == PH_REQ) begin
        chk("req_cmd", uhost_req_cmd, m_cmd);
        chk("req_dst", uhost_req_dstaddr, m_dst);
        chk("req_src", uhost_req_srcaddr, SRCA);
        chk("req_data", uhost_req_data, m_data);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_end(input int bound, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (!(cfg_done || cfg_error) && n < bound);
    chk({nm, "_finished"}, cfg_done || cfg_error, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n_done;
    bit seen;
    int abort_at;
    tick(3);
    reset = 1'b0;
    tick(2);

    // Normal run with fixed config and zero-latency handshakes
    cfg_crdt_req = 16'h1234; cfg_crdt_resp = 16'h5678; cfg_crdt_intrvl = 16'h00ff;
    cfg_rxiowidth = 8'h02; cfg_txiowidth = 8'h03; cfg_txcrdt_en = 1'b1;
    log_dst.delete(); log_data.delete(); log_cmd.delete();
    start = 1'b1; t0 = cyc;
    wait_end(60, "norm");
    chk("norm_done_latency", 64'(cyc - t0), 11);
    chk("norm_done", cfg_done, 1);
    chk("norm_nreq", 64'(log_dst.size()), 5);
    if (log_dst.size() == 5) begin
      chk("norm_dst0", log_dst[0], 64'h20);
      chk("norm_dst1", log_dst[1], 64'h24);
      chk("norm_dst2", log_dst[2], 64'h14);
      chk("norm_dst3", log_dst[3], 64'h10);
      chk("norm_dst4", log_dst[4], 64'h04);
      chk("norm_data0", log_data[0], 32'h5678_1234);
      chk("norm_data1", log_data[1], 32'h0000_00ff);
      chk("norm_data2", log_data[2], 32'h0002_0001);
      chk("norm_data3", log_data[3], 32'h0003_0011);
      chk("norm_data4", log_data[4], 32'h0);
      chk("norm_cmd_wr", log_cmd[0], 32'h43);
      chk("norm_cmd_rd", log_cmd[4], 32'h41);
    end
    tick(1); start = 1'b0; tick(4);
    chk("norm_release", {cfg_busy, cfg_done, cfg_error}, 0);

    // Backpressure on step 2 while config inputs churn
    cfg_rand = 1'b1; stall_off = 8'h14; stall_left = 5; stall_cnt = 0;
    start = 1'b1;
    wait_end(80, "bp");
    chk("bp_stall_cycles", 64'(stall_cnt), 5);
    chk("bp_done", cfg_done, 1);
    start = 1'b0; tick(6);

    // Timeout on step 1
    drop_en = 1'b1; drop_off = 8'h24;
    start = 1'b1;
    wait_end(1200, "tmo");
    chk("tmo_error", cfg_error, 1);
    chk("tmo_cycles", 64'(cyc - hs_edge_24), 64'(TMO));
    chk("tmo_step", cfg_step, 1);
    tick(1); start = 1'b0; tick(1);
    chk("tmo_cleared", {cfg_busy, cfg_done, cfg_error}, 0);
    drop_en = 1'b0; tick(4);

    // Remote link inactive
    status_val = 32'h0;
    start = 1'b1;
    wait_end(60, "badstat");
    chk("badstat_error", cfg_error, 1);
    chk("badstat_step", cfg_step, 4);
    start = 1'b0; tick(4);
    status_val = 32'h10;

    // Read-response opcode returned for a write
    badop_en = 1'b1; badop_off = 8'h20;
    start = 1'b1;
    wait_end(60, "badop");
    chk("badop_error", cfg_error, 1);
    chk("badop_step", cfg_step, 0);
    start = 1'b0; tick(4);
    badop_en = 1'b0;

    // Abort in WAIT of step 3 with a late response
    lat_min = 4; lat_max = 4; t0 = 0;
    start = 1'b1;
    do begin @(negedge clk); t0++; end
      while (!(cfg_busy && !uhost_req_valid && cfg_step == 3) && t0 < 100);
    chk("abort_reached_wait3", cfg_step, 3);
    @(posedge clk); #1; start = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (uhost_resp_valid) begin
        seen = 1'b1;
        chk("abort_drain_ready", uhost_resp_ready, 1);
        chk("abort_idle", {cfg_busy, cfg_done, cfg_error}, 0);
      end
    end
    chk("abort_late_resp", seen, 1);
    lat_min = 0; lat_max = 0;
    log_dst.delete(); log_data.delete(); log_cmd.delete();
    @(posedge clk); #1; start = 1'b1;
    wait_end(80, "restart");
    chk("restart_done", cfg_done, 1);
    chk("restart_first_dst", (log_dst.size() > 0) ? log_dst[0] : 64'hdead, 64'h20);
    start = 1'b0; tick(4);

    // Asynchronous reset during ISSUE
    ready_pct = 0;
    start = 1'b1; t0 = 0;
    do begin @(negedge clk); t0++; end while (!uhost_req_valid && t0 < 20);
    chk("rst_mid_issue_valid", uhost_req_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", uhost_req_valid, 0);
    chk("arst_flags", {cfg_busy, cfg_done, cfg_error}, 0);
    chk("arst_step", cfg_step, 0);
    chk("arst_resp_ready", uhost_resp_ready, 1);
    chk("arst_fields", {uhost_req_cmd, uhost_req_data}, 0);
    start = 1'b0;
    @(posedge clk); #1; reset = 1'b0; ready_pct = 100;
    tick(3);

    // Randomized sequences
    n_done = 0;
    for (int it = 0; it < 60; it++) begin
      ready_pct  = $urandom_range(30, 100);
      lat_min    = 0;
      lat_max    = $urandom_range(0, 3);
      bad_pct    = (it % 4 == 0) ? 20 : 0;
      case ($urandom_range(0, 3))
        0: status_val = 32'h0;
        1: status_val = 32'h1ef;
        default: status_val = 32'h10 | ($urandom & 32'hffff_ffef) | 32'h10;
      endcase
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : -1;
      start = 1'b1;
      for (int c = 0; c < 200; c++) begin
        tick(1);
        if (c == abort_at || cfg_done || cfg_error) break;
      end
      if (cfg_done) n_done++;
      start = 1'b0;
      tick(8);
    end
    chk("rand_some_done", n_done > 0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
